// File: rtl/gate_tt_checker_if.sv
// Gate-side link of the truth-table checker: the stimulus vector
// goes to the gate under test and the gate's output comes back.
interface gate_tt_checker_if #(
  parameter int N_IN = 2
);
  logic [N_IN-1:0] dut_in;
  logic            dut_y;

  modport master (
    output dut_in,
    input  dut_y
  );

  modport slave (
    input  dut_in,
    output dut_y
  );
endinterface

// File: rtl/gate_tt_checker.sv
// Exhaustive truth-table sweep of an N-input gate.
// Each vector is held SETTLE cycles, then dut_y is checked.
module gate_tt_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          func,
  gate_tt_checker_if.master   g,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_cnt,
  output logic                fail_valid,
  output logic [N_IN-1:0]     fail_vec
);

  localparam int         EW    = N_IN + 1;
  localparam logic [3:0] SET_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      func_q;
  logic [N_IN-1:0] vec_q;
  logic [3:0]      cnt_q;
  logic            go;
  logic            smp;
  logic            last;
  logic            exp_y;
  logic            mis;
  logic [N_IN:0]   err_nxt;

  assign go      = start && (state_q != RUN);
  assign smp     = (state_q == RUN) && (cnt_q == 4'd1);
  assign last    = &vec_q;
  assign mis     = smp && (g.dut_y != exp_y);
  assign err_nxt = err_cnt + EW'(mis);
  assign g.dut_in = vec_q;

  always_comb begin
    exp_y = 1'b0;
    unique case (func_q)
      3'd0:    exp_y = &vec_q;
      3'd1:    exp_y = |vec_q;
      3'd2:    exp_y = ~&vec_q;
      3'd3:    exp_y = ~|vec_q;
      3'd4:    exp_y = ^vec_q;
      3'd5:    exp_y = ~^vec_q;
      default: exp_y = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (smp && last) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // The final sample's mismatch is folded into pass via err_nxt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q     <= '0;
      vec_q      <= '0;
      cnt_q      <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (go) begin
      func_q     <= func;
      vec_q      <= '0;
      cnt_q      <= SET_L;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (state_q == RUN) begin
      if (smp) begin
        err_cnt <= err_nxt;
        if (mis && !fail_valid) begin
          fail_vec   <= vec_q;
          fail_valid <= 1'b1;
        end
        if (last) begin
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end else begin
          vec_q <= vec_q + 1'b1;
          cnt_q <= SET_L;
        end
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench: a 2-input NOR checker (SETTLE=2) and a 3-input XOR
// checker (SETTLE=1), with optional per-vector output flips.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  gate_tt_checker_if #(.N_IN(2)) g2 ();
  logic       start2 = 1'b0;
  logic [2:0] func2 = 3'd0;
  logic       busy2, done2, pass2, fv2;
  logic [2:0] err2;
  logic [1:0] fvec2;
  logic [3:0] flip2 = '0;

  gate_tt_checker_if #(.N_IN(3)) g3 ();
  logic       start3 = 1'b0;
  logic [2:0] func3 = 3'd0;
  logic       busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] fvec3;
  logic [7:0] flip3 = '0;

  assign g2.dut_y = ~(g2.dut_in[1] | g2.dut_in[0]) ^ flip2[g2.dut_in];
  assign g3.dut_y = (^g3.dut_in) ^ flip3[g3.dut_in];

  gate_tt_checker #(.N_IN(2), .SETTLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .func(func2),
    .g(g2.master), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_valid(fv2), .fail_vec(fvec2)
  );

  gate_tt_checker #(.N_IN(3), .SETTLE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .func(func3),
    .g(g3.master), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_valid(fv3), .fail_vec(fvec3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit expect_fn(input int f, input int n, input int v);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (f)
      0: return ones == n;
      1: return ones > 0;
      2: return ones != n;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Reference sweep: gate kind 3 = NOR, 4 = XOR, plus flip mask.
  function automatic void model(input int n, input int kind, input int f,
                                input logic [7:0] flip, output int errs,
                                output int first, output bit fv);
    bit y;
    errs = 0; first = 0; fv = 0;
    for (int v = 0; v < (1 << n); v++) begin
      y = expect_fn(kind, n, v) ^ flip[v];
      if (y != expect_fn(f, n, v)) begin
        if (!fv) first = v;
        fv = 1;
        errs++;
      end
    end
  endfunction

  task automatic run2(input int f, input bit mid);
    int e, fi;
    bit fv;
    model(2, 3, f, {4'b0, flip2}, e, fi, fv);
    @(negedge clk);
    func2 = 3'(f);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("n2_start_busy", busy2, 1);
    chk("n2_start_done", done2, 0);
    chk("n2_start_err", err2, 0);
    chk("n2_start_vec", g2.dut_in, 0);
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      if (mid && t == 2) begin start2 = 1'b1; func2 = 3'd1; end
      if (mid && t == 3) start2 = 1'b0;
      if (t < 8) begin
        chk($sformatf("n2_vec_t%0d", t), g2.dut_in, t / 2);
        chk($sformatf("n2_done_t%0d", t), done2, 0);
      end else begin
        chk("n2_done", done2, 1);
        chk("n2_busy", busy2, 0);
        chk("n2_vec_end", g2.dut_in, 3);
      end
    end
    chk("n2_err", err2, e);
    chk("n2_fv", fv2, fv);
    if (fv) chk("n2_fvec", fvec2, fi);
    chk("n2_pass", pass2, e == 0);
  endtask

  task automatic run3(input int f);
    int e, fi;
    bit fv;
    model(3, 4, f, flip3, e, fi, fv);
    @(negedge clk);
    func3 = 3'(f);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    chk("x3_start_done", done3, 0);
    chk("x3_start_err", err3, 0);
    chk("x3_start_vec", g3.dut_in, 0);
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      if (t < 8) begin
        chk($sformatf("x3_vec_t%0d", t), g3.dut_in, t);
        chk($sformatf("x3_done_t%0d", t), done3, 0);
      end else begin
        chk("x3_done", done3, 1);
        chk("x3_vec_end", g3.dut_in, 7);
      end
    end
    chk("x3_err", err3, e);
    chk("x3_fv", fv3, fv);
    if (fv) chk("x3_fvec", fvec3, fi);
    chk("x3_pass", pass3, e == 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_pass", pass2, 0);
    chk("rst_err", err2, 0);
    chk("rst_fv", fv2, 0);
    chk("rst_vec", g2.dut_in, 0);
    chk("rst_vec3", g3.dut_in, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run2(3, 1'b0);
    chk("nor_pass", pass2, 1);
    run2(0, 1'b0);
    chk("and_err", err2, 2);
    chk("and_fvec", fvec2, 0);
    run2(3, 1'b1);
    chk("mid_pass", pass2, 1);

    // Asynchronous reset between edges 5 and 6 of a failing sweep.
    @(negedge clk);
    func2 = 3'd0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_err", err2, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy2, 0);
    chk("arst_vec", g2.dut_in, 0);
    chk("arst_err", err2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run2(3, 1'b0);
    chk("post_rst_pass", pass2, 1);

    run3(4);
    chk("xor_pass", pass3, 1);
    run3(5);
    chk("xnor_err", err3, 8);
    chk("xnor_fvec", fvec3, 0);

    for (int i = 0; i < 8; i++) begin
      flip2 = 4'($urandom);
      run2(int'($urandom_range(0, 7)), 1'b0);
      flip3 = 8'($urandom);
      run3(int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Self-checking stimulus stage for the switch-level gate library: on `start` it walks every input combination of an N-input gate, drives each vector onto the gate inputs, and samples the gate output after a programmable settle time. It compares each sample against the expected value for a selected logic function and reports pass/fail, error count and first failing vector. It sits directly upstream of the gate under test, such as the switch-level NOR gate, and consumes that gate's output, replacing hand-written stimulus sequences.

## Interface
- `N_IN`, 2, number of gate inputs; legal range 1..4.
- `SETTLE`, 2, clock cycles each vector is held before `dut_y` is sampled; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `start`  input  1  begin a sweep; sampled on a clock edge; honoured only in IDLE or DONE.
- `func`  input  3  expected function, latched at start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved (expected = 0).
- `dut_in`  output  N_IN  vector driven to the gate; bit N_IN-1 = first gate input (`a`), bit 0 = last (`b` for 2 inputs).
- `dut_y`  input  1  gate output.
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  high from sweep completion until the next start or reset.
- `pass`  output  1  valid when `done`=1; 1 iff `err_cnt`==0.
- `err_cnt`  output  N_IN+1  number of mismatching vectors in the current or last sweep.
- `fail_valid`  output  1  at least one mismatch seen this sweep.
- `fail_vec`  output  N_IN  first mismatching vector; valid when `fail_valid`=1.

## Operation
- States:
  - IDLE: after reset.
  - RUN: sweep in progress.
  - DONE: results held.
- Reset (async, any state, including mid-sweep): state IDLE, and all outputs 0, including `dut_in`. The internal vector counter and settle counter are cleared.
- IDLE/DONE with `start`=1 at an edge:
  - `func` is latched.
  - `err_cnt`, `fail_valid`, `fail_vec`, `done` and `pass` are cleared.
  - `dut_in` is set to 0 and the settle counter is loaded with SETTLE.
  - The state moves to RUN, and `busy` is 1.
- RUN:
  - The settle counter decrements every edge. When it reaches 1 (i.e. at the SETTLE-th edge after `dut_in` last changed), `dut_y` is sampled and compared with expected(`func`, `dut_in`).
  - On a mismatch, `err_cnt` increments. If `fail_valid`=0, `fail_vec` is set to `dut_in` and `fail_valid` is set to 1.
  - At that same sample edge, if `dut_in` is not all-ones, it increments by 1 and the settle counter reloads.
  - Otherwise the state moves to DONE: `busy` goes to 0, `done` to 1, and `pass` to (final `err_cnt`==0). The final mismatch is included in the `pass` value at that same edge.
- `start` is ignored during RUN. Changes to `func` during RUN are ignored, because the latched copy is used.
- Expected value:
  - Reduction of all N_IN bits of `dut_in` (AND/OR/XOR), with inversion for NAND/NOR/XNOR.
  - For N_IN=1, AND/OR/XOR reduce to a buffer and NAND/NOR/XNOR to an inverter.
- Vector order is ascending binary from 0 to 2^N_IN−1. `err_cnt` saturation is not needed because its width holds 2^N_IN.
- DONE holds all results and keeps `dut_in` at all-ones until the next start.
- `dut_y` is compared with plain inequality; the bench must not drive X.

## Timing
- `start` edge = cycle 0. Vector k is on `dut_in` from edge k·SETTLE and is sampled at edge (k+1)·SETTLE.
- `done` and `pass` are valid after edge 2^N_IN·SETTLE. Default latency is 8 cycles.
- All outputs are registered, with no combinational path from `dut_y` or `start` to any output.
- A `start` in DONE behaves exactly like a `start` in IDLE: results clear at the same edge, and `done` falls.

## Test plan
- **Correct NOR, default parameters.** Connect a behavioural NOR (y = ~(a|b)) with `dut_in[1]`=a and `dut_in[0]`=b. Set `func`=3 and pulse `start`.
  - Required: `dut_in` steps 00, 01, 10, 11, each held for 2 cycles.
  - Required: `done`=1 and `pass`=1 at cycle 8, with `err_cnt`=0 and `fail_valid`=0.
- **Wrong function.** Same NOR, `func`=0 (AND).
  - Required: mismatches at 00 and 11, giving `err_cnt`=2, `fail_vec`=00, `fail_valid`=1, `pass`=0 and `done` at cycle 8.
- **Start during RUN.** Pulse `start` again at cycle 3 and change `func` to 1.
  - Required: the sweep is unaffected, with results identical to the first scenario and `done` still at cycle 8.
- **Reset mid-sweep.** Assert `rst_n`=0 asynchronously at cycle 5, between edges.
  - Required: `busy`, `dut_in` and `err_cnt` are 0 immediately.
  - Required: after release, a new `start` gives a full correct sweep.
- **Three-input XOR, back-to-back runs.** N_IN=3, SETTLE=1, 3-input XOR model, `func`=4.
  - Required: 8 vectors, one cycle each, with `done` at cycle 8 and `pass`=1.
  - Then `start` from DONE with `func`=5: `err_cnt`=8, `fail_vec`=000, and `done` at cycle 8 of the new run.
